// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the MEM stage and a single-port,
// word-wide data memory. Loads get byte/half lane extraction with sign or
// zero extension. SB/SH are done as read-modify-write because the memory
// only has a whole-word write enable. SW is a single write.
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When it is defined,
// misaligned half/word accesses complete with rsp_err instead of touching
// memory.
module lsu_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    RMW_RD   = 3'd2,
    RMW_WR   = 3'd3,
    STORE_W  = 3'd4,
`ifdef LSU_MISALIGN_TRAP_EN
    RESP     = 3'd5,
    ERR_RESP = 3'd6
`else
    RESP     = 3'd5
`endif
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  // Holds the store data, and for SB/SH is overwritten with the merged word.
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              accept;

  assign accept = req_valid && req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign;
  // Half needs addr[0]==0, word (size 10 or 11) needs addr[1:0]==0.
  assign misalign = (req_size == 2'b01) ? req_addr[0]
                  : (req_size[1]        ? (|req_addr[1:0]) : 1'b0);
`endif

  // Lane select plus sign/zero extension of a little-endian memory word.
  function automatic logic [DATA_W-1:0] load_ext(
    input logic [DATA_W-1:0] word,
    input logic [1:0]        lane,
    input logic [1:0]        size,
    input logic              uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   load_ext = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   load_ext = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: load_ext = word;
    endcase
  endfunction

  // Replace the addressed byte or half of the old word with store data.
  function automatic logic [DATA_W-1:0] merge_lane(
    input logic [DATA_W-1:0] word,
    input logic [DATA_W-1:0] wd,
    input logic [1:0]        lane,
    input logic [1:0]        size
  );
    logic [DATA_W-1:0] m;
    m = word;
    if (size == 2'b00) begin
      case (lane)
        2'd0:    m[7:0]   = wd[7:0];
        2'd1:    m[15:8]  = wd[7:0];
        2'd2:    m[23:16] = wd[7:0];
        default: m[31:24] = wd[7:0];
      endcase
    end else if (size == 2'b01) begin
      if (lane[1]) m[31:16] = wd[15:0];
      else         m[15:0]  = wd[15:0];
    end
    merge_lane = m;
  endfunction

  // State register; reset aborts any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
`ifdef LSU_MISALIGN_TRAP_EN
          if (misalign)         state_next = ERR_RESP;
          else if (!req_we)     state_next = LOAD;
`else
          if (!req_we)          state_next = LOAD;
`endif
          else if (req_size[1]) state_next = STORE_W;
          else                  state_next = RMW_RD;
        end
      end
      LOAD:     state_next = RESP;
      RMW_RD:   state_next = RMW_WR;
      RMW_WR:   state_next = RESP;
      STORE_W:  state_next = RESP;
      RESP:     state_next = IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
      ERR_RESP: state_next = IDLE;
`endif
      default:  state_next = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    req_ready = (state == IDLE);
    mem_we    = (state == RMW_WR) || (state == STORE_W);
`ifdef LSU_MISALIGN_TRAP_EN
    rsp_valid = (state == RESP) || (state == ERR_RESP);
    rsp_err   = (state == ERR_RESP);
`else
    rsp_valid = (state == RESP);
    rsp_err   = 1'b0;
`endif
  end

  // Request latch, load result and RMW merge registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        wdata_q <= req_wdata;
      end
      if (state == LOAD)
        rdata_q <= load_ext(mem_rdata, addr_q[1:0], size_q, uns_q);
      if (state == RMW_RD)
        wdata_q <= merge_lane(mem_rdata, wdata_q, addr_q[1:0], size_q);
    end
  end

  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a behavioural word memory and a response
// scoreboard. Works with or without LSU_MISALIGN_TRAP_EN.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [7:0]  req_addr = 8'h00;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  lsu_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural data memory with a preload port for the bench.
  logic [31:0] mem [0:63];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = 6'd0;
  logic [31:0] pre_val = 32'h0;

  always @(posedge clk) begin
    if (pre_we)      mem[pre_idx] <= pre_val;
    else if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr[7:2]];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response monitor: every rsp_valid must match the oldest expectation.
  exp_t mon_e;
  always @(negedge clk) begin
    if (mem_we) we_cnt++;
    if (rst_n && rsp_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        mon_e = q.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
      end
    end
  end

  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [7:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_lat, input int exp_we);
    int n;
    int we0;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    q.push_back('{rdata: exp_rd, err: exp_err});
    we0 = we_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 10);
    chk({tag, "_lat"}, n, exp_lat);
    @(negedge clk);
    chk({tag, "_we_cycles"}, we_cnt - we0, exp_we);
  endtask

  logic [31:0] exp_w10;
  int n, acc, rs, n1, n2, we0;

  initial begin
    // Reset, with the preload happening while reset is held.
    @(negedge clk);
    pre_we = 1'b1; pre_idx = 6'd4; pre_val = 32'h8899AABB;
    @(negedge clk);
    pre_we = 1'b0;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_addr", {24'b0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;

    // Loads from word 0x10 = 0x8899AABB.
    do_req("lb_12",  1'b0, 2'b00, 1'b0, 8'h12, 32'h0, 32'hFFFFFF99, 1'b0, 2, 0);
    do_req("lbu_12", 1'b0, 2'b00, 1'b1, 8'h12, 32'h0, 32'h00000099, 1'b0, 2, 0);
    do_req("lh_12",  1'b0, 2'b01, 1'b0, 8'h12, 32'h0, 32'hFFFF8899, 1'b0, 2, 0);
    do_req("lhu_10", 1'b0, 2'b01, 1'b1, 8'h10, 32'h0, 32'h0000AABB, 1'b0, 2, 0);

    // SB read-modify-write; rsp_rdata keeps the last load result.
    do_req("sb_11",  1'b1, 2'b00, 1'b0, 8'h11, 32'h123456CC, 32'h0000AABB, 1'b0, 3, 1);
    chk("mem_after_sb", mem[4], 32'h8899CCBB);
    do_req("lw_10",  1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 32'h8899CCBB, 1'b0, 2, 0);
    do_req("lb_13",  1'b0, 2'b00, 1'b0, 8'h13, 32'h0, 32'hFFFFFF88, 1'b0, 2, 0);

    // SW then LW with req_valid held high across both.
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 8'h14; req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
    q.push_back('{rdata: 32'hFFFFFF88, err: 1'b0});
    q.push_back('{rdata: 32'hDEADBEEF, err: 1'b0});
    we0 = we_cnt;
    @(posedge clk);
    #1 req_we = 1'b0; req_wdata = 32'h0;
    n = 0; acc = 0; rs = 0; n1 = 0; n2 = 0;
    while (n < 12 && rs < 2) begin
      @(negedge clk);
      n++;
      if (rsp_valid) begin
        rs++;
        if (rs == 1) n1 = n;
        else         n2 = n;
      end
      if (req_ready && acc == 0) begin
        acc = n;
        @(posedge clk);
        #1 req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk("b2b_sw_lat", n1, 32'd2);
    chk("b2b_accept_cycle", acc, 32'd3);
    chk("b2b_lw_lat", n2, 32'd5);
    @(negedge clk);
    chk("b2b_we_cycles", we_cnt - we0, 32'd1);
    chk("mem_after_sw", mem[5], 32'hDEADBEEF);

    // Size 11 behaves as a word access.
    do_req("lw11_14", 1'b0, 2'b11, 1'b0, 8'h14, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);

    // SH at an odd address.
`ifdef LSU_MISALIGN_TRAP_EN
    do_req("sh_13", 1'b1, 2'b01, 1'b0, 8'h13, 32'h00007777, 32'hDEADBEEF, 1'b1, 1, 0);
    exp_w10 = 32'h8899CCBB;
`else
    do_req("sh_13", 1'b1, 2'b01, 1'b0, 8'h13, 32'h00007777, 32'hDEADBEEF, 1'b0, 3, 1);
    exp_w10 = 32'h7777CCBB;
`endif
    chk("mem_after_sh", mem[4], exp_w10);
    do_req("lw_10b", 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, exp_w10, 1'b0, 2, 0);

    // Misaligned word load: trap, or aligned word without the trap.
`ifdef LSU_MISALIGN_TRAP_EN
    do_req("lw_11", 1'b0, 2'b10, 1'b0, 8'h11, 32'h0, exp_w10, 1'b1, 1, 0);
`else
    do_req("lw_11", 1'b0, 2'b10, 1'b0, 8'h11, 32'h0, exp_w10, 1'b0, 2, 0);
`endif

    // SB aborted by reset during RMW_RD.
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 8'h10; req_wdata = 32'h00000055; req_valid = 1'b1;
    we0 = we_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_mem_we", {31'b0, mem_we}, 32'd0);
    chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("abort_rsp_rdata", rsp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_we_cycles", we_cnt - we0, 32'd0);
    chk("abort_mem", mem[4], exp_w10);
    chk("abort_ready_after", {31'b0, req_ready}, 32'd1);
    do_req("lw_after_abort", 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, exp_w10, 1'b0, 2, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
